program_load_controller: RTL

- Sequences loading of the 8-bit program memory from a byte stream (UART receiver or switch/button source), then verifies the contents by readback checksum.
- After a successful check, hands the memory port to the CPU.
- Owns the single memory write/read port: the loader drives it during load/verify; the CPU drives it only in RUN.

---
 rtl/program_load_controller.sv | 122 ++++++++++++
 1 files changed

// File: rtl/program_load_controller.sv
// Program loader: streams LOAD_LENGTH bytes into memory, checks a trailing checksum
// against a readback sum, then hands the memory port to the CPU.
module program_load_controller #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int LOAD_LENGTH = 256
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] rx_data_in,
    input  logic                  rx_valid_in,
    output logic                  rx_ready_out,
    input  logic [DATA_WIDTH-1:0] mem_rdata_in,
    input  logic [ADDR_WIDTH-1:0] cpu_address_in,
    input  logic [DATA_WIDTH-1:0] cpu_data_in,
    input  logic                  cpu_wr_en_in,
    output logic [ADDR_WIDTH-1:0] mem_address_out,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_wr_en_out,
    output logic                  busy_out,
    output logic                  run_out,
    output logic                  error_out
);
    // One extra counter bit so VERIFY can count to LOAD_LENGTH when it equals 2^ADDR_WIDTH.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(LOAD_LENGTH - 1);
    localparam logic [CW-1:0] LEN  = CW'(LOAD_LENGTH);

    typedef enum logic [2:0] {IDLE, LOAD, CKSUM, VERIFY, RUN, ERROR} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] load_sum;
    logic [DATA_WIDTH-1:0] rb_sum;
    logic [DATA_WIDTH-1:0] expected;
    logic [DATA_WIDTH-1:0] rb_final;
    logic                  xfer;

    assign rx_ready_out = (state == LOAD) || (state == CKSUM);
    assign xfer         = rx_valid_in && rx_ready_out;
    assign rb_final     = rb_sum + mem_rdata_in;
    assign busy_out     = (state == LOAD) || (state == CKSUM) || (state == VERIFY);
    assign run_out      = (state == RUN);
    assign error_out    = (state == ERROR);

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state    <= IDLE;
            count    <= '0;
            load_sum <= '0;
            rb_sum   <= '0;
            expected <= '0;
        end else begin
            case (state)
                IDLE, RUN, ERROR: begin
                    if (start_in) begin
                        state    <= LOAD;
                        count    <= '0;
                        load_sum <= '0;
                        rb_sum   <= '0;
                        expected <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        load_sum <= load_sum + rx_data_in;
                        if (count == LAST) begin
                            count <= '0;
                            state <= CKSUM;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                CKSUM: begin
                    if (xfer) begin
                        expected <= rx_data_in;
                        rb_sum   <= '0;
                        count    <= '0;
                        state    <= VERIFY;
                    end
                end
                VERIFY: begin
                    // Read data lags the address by one cycle, so cycle 0 has nothing to add.
                    if (count == LEN) begin
                        count <= '0;
                        state <= (rb_final == expected && rb_final == load_sum) ? RUN : ERROR;
                    end else begin
                        if (count != '0) rb_sum <= rb_final;
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_address_out = '0;
        mem_data_out    = '0;
        mem_wr_en_out   = 1'b0;
        case (state)
            LOAD: begin
                mem_address_out = count[ADDR_WIDTH-1:0];
                if (xfer) begin
                    mem_data_out  = rx_data_in;
                    mem_wr_en_out = 1'b1;
                end
            end
            VERIFY: begin
                if (count != LEN) mem_address_out = count[ADDR_WIDTH-1:0];
            end
            RUN: begin
                mem_address_out = cpu_address_in;
                mem_data_out    = cpu_data_in;
                mem_wr_en_out   = cpu_wr_en_in;
            end
            default: ;
        endcase
    end
endmodule
